// File: rtl/eeprom_pkg.sv
// Shared types for the 2048x8 EEPROM array and its two-port arbiter.
// Port ids, request bundle and default geometry.
package eeprom_pkg;

  localparam int EEPROM_ADDR_W = 11;
  localparam int EEPROM_DATA_W = 8;

  typedef enum logic [0:0] {
    P_I2C  = 1'b0,
    P_HOST = 1'b1
  } port_id_t;

  typedef struct packed {
    logic                     we;
    logic [EEPROM_ADDR_W-1:0] addr;
    logic [EEPROM_DATA_W-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/eeprom_mem_if.sv
// Valid/ready request channel with registered read-data return,
// one instance per EEPROM requester.
interface eeprom_mem_if
  import eeprom_pkg::*;
#(
  parameter int ADDR_W = EEPROM_ADDR_W,
  parameter int DATA_W = EEPROM_DATA_W
);

  logic              valid;
  logic              ready;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (
    output valid, we, addr, wdata,
    input  ready, rvalid, rdata
  );

  modport slave (
    input  valid, we, addr, wdata,
    output ready, rvalid, rdata
  );

endinterface

// File: rtl/eeprom_rr_arb2.sv
// Two-input round-robin grant with last-grant register.
// Ties go to the port not granted most recently.
module eeprom_rr_arb2
  import eeprom_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       busy,
  input  logic       xfer,
  output logic [1:0] gnt,
  output port_id_t   last_grant
);

  port_id_t last_q, last_d;

  always_comb begin
    gnt = 2'b00;
    if (!busy) begin
      unique case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = (last_q == P_HOST) ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

  always_comb begin
    last_d = last_q;
    if (xfer) last_d = gnt[1] ? P_HOST : P_I2C;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_q <= P_HOST;
    else     last_q <= last_d;
  end

  assign last_grant = last_q;

endmodule

// File: rtl/eeprom_mem_arbiter.sv
// EEPROM byte array shared by I2C (p0) and host (p1) ports.
// Define WRITE_BUSY_EN to stall both ports for TWR_CYCLES after each write.
module eeprom_mem_arbiter
  import eeprom_pkg::*;
#(
  parameter int ADDR_W     = EEPROM_ADDR_W,
  parameter int DATA_W     = EEPROM_DATA_W,
  parameter int TWR_CYCLES = 5000
) (
  input  logic        clk,
  input  logic        rst,
  eeprom_mem_if.slave p0,
  eeprom_mem_if.slave p1,
  output logic        busy,
  output logic        last_grant
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [1:0]  req;
  logic [1:0]  gnt;
  logic        xfer;
  port_id_t    lg;
  mem_req_t    sel;
  logic        wr_en;
  logic        rd_en;
  logic [DATA_W-1:0] rd_word;

  logic [1:0]        rvalid_q, rvalid_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;

  // Masking requests with rst keeps a write from landing while reset is held
  assign req = {p1.valid, p0.valid} & {2{~rst}};

  eeprom_rr_arb2 u_arb (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .busy       (busy),
    .xfer       (xfer),
    .gnt        (gnt),
    .last_grant (lg)
  );

  assign xfer       = |gnt;
  assign p0.ready   = gnt[0];
  assign p1.ready   = gnt[1];
  assign last_grant = lg;

  always_comb begin
    sel = '{we: p0.we, addr: p0.addr, wdata: p0.wdata};
    if (gnt[1]) sel = '{we: p1.we, addr: p1.addr, wdata: p1.wdata};
  end

  assign wr_en   = xfer & sel.we;
  assign rd_en   = xfer & ~sel.we;
  assign rd_word = mem[sel.addr];

  always_ff @(posedge clk) begin
    if (wr_en) mem[sel.addr] <= sel.wdata;
  end

  always_comb begin
    rvalid_d = {2{rd_en}} & gnt;
    rdata0_d = rvalid_d[0] ? rd_word : rdata0_q;
    rdata1_d = rvalid_d[1] ? rd_word : rdata1_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rvalid_q <= 2'b00;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      rvalid_q <= rvalid_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  assign p0.rvalid = rvalid_q[0];
  assign p1.rvalid = rvalid_q[1];
  assign p0.rdata  = rdata0_q;
  assign p1.rdata  = rdata1_q;

`ifdef WRITE_BUSY_EN
  localparam int CNT_W = $clog2(TWR_CYCLES + 1);
  localparam logic [CNT_W-1:0] TWR_LOAD = CNT_W'(TWR_CYCLES);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Grants resume on the cycle the count reaches zero
  always_comb begin
    cnt_d = cnt_q;
    if (wr_en)              cnt_d = TWR_LOAD;
    else if (cnt_q != '0)   cnt_d = cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign busy = (cnt_q != '0);
`else
  assign busy = 1'b0;
`endif

endmodule

// File: tb/tb_eeprom_mem_arbiter.sv
// Randomised + directed bench for eeprom_mem_arbiter with an in-bench
// behavioural model; honours WRITE_BUSY_EN when defined.
module tb_eeprom_mem_arbiter;
  import eeprom_pkg::*;

  localparam int AW  = 11;
  localparam int DW  = 8;
  localparam int TWR = 8;
`ifdef WRITE_BUSY_EN
  localparam int BUSY_ON = 1;
`else
  localparam int BUSY_ON = 0;
`endif

  typedef struct {
    bit we;
    int addr;
    int data;
  } op_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  eeprom_mem_if #(.ADDR_W(AW), .DATA_W(DW)) i0 ();
  eeprom_mem_if #(.ADDR_W(AW), .DATA_W(DW)) i1 ();
  logic busy, last_grant;

  eeprom_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TWR_CYCLES(TWR)) dut (
    .clk        (clk),
    .rst        (rst),
    .p0         (i0),
    .p1         (i1),
    .busy       (busy),
    .last_grant (last_grant)
  );

  logic [1:0]    v = 2'b00;
  logic [1:0]    we_ = 2'b00;
  logic [AW-1:0] ad [2];
  logic [DW-1:0] wd [2];
  logic [1:0]    r, rv;
  logic [DW-1:0] rd [2];

  assign i0.valid = v[0];
  assign i1.valid = v[1];
  assign i0.we    = we_[0];
  assign i1.we    = we_[1];
  assign i0.addr  = ad[0];
  assign i1.addr  = ad[1];
  assign i0.wdata = wd[0];
  assign i1.wdata = wd[1];
  assign r        = {i1.ready, i0.ready};
  assign rv       = {i1.rvalid, i0.rvalid};
  assign rd[0]    = i0.rdata;
  assign rd[1]    = i1.rdata;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  bit chk_on = 0;
  bit [1:0] xs = 2'b00;
  op_t q [2][$];
  int glog [$];
  int gcyc [$];
  int rlog [2][$];
  int busy_cycles = 0;

  logic [DW-1:0] m_mem [2048];
  bit   m_known [2048];
  int   m_last = 1;
  int   m_busy = 0;
  bit [1:0] m_rv = 2'b00;
  int   m_rd [2];
  bit   m_rdk [2];

  function automatic void check(input string nm, input longint act,
                                input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  function automatic int model_grant();
    if (rst || m_busy > 0) return -1;
    if (v[0] && v[1]) return (m_last == 1) ? 0 : 1;
    if (v[0]) return 0;
    if (v[1]) return 1;
    return -1;
  endfunction

  always @(posedge clk) cyc++;

  // Reference model: array, last grant, busy count, pending reads
  always @(posedge clk or posedge rst) begin
    int g;
    if (rst) begin
      m_last = 1;
      m_busy = 0;
      m_rv = 2'b00;
      m_rd[0] = 0;
      m_rd[1] = 0;
      m_rdk[0] = 1;
      m_rdk[1] = 1;
    end else begin
      g = model_grant();
      m_rv = 2'b00;
      if (m_busy > 0) m_busy--;
      if (g >= 0) begin
        m_last = g;
        if (we_[g]) begin
          m_mem[ad[g]] = wd[g];
          m_known[ad[g]] = 1;
          if (BUSY_ON != 0) m_busy = TWR;
        end else begin
          m_rv[g] = 1;
          m_rd[g] = int'(m_mem[ad[g]]);
          m_rdk[g] = m_known[ad[g]];
        end
      end
    end
  end

  always @(negedge clk) begin
    int g;
    if (chk_on) begin
      g = model_grant();
      check("p0_ready", r[0], g == 0);
      check("p1_ready", r[1], g == 1);
      for (int p = 0; p < 2; p++) begin
        check($sformatf("p%0d_rvalid", p), rv[p], m_rv[p]);
        if (m_rdk[p]) check($sformatf("p%0d_rdata", p), rd[p], m_rd[p]);
      end
      check("busy", busy, m_busy > 0);
      check("last_grant", last_grant, m_last);
      for (int p = 0; p < 2; p++) begin
        if (v[p] && r[p]) begin
          glog.push_back(p);
          gcyc.push_back(cyc);
        end
        if (rv[p]) rlog[p].push_back(int'(rd[p]));
      end
      if (busy) busy_cycles++;
    end
    xs = v & r;
  end

  task automatic step();
    op_t o;
    @(posedge clk);
    #1;
    for (int p = 0; p < 2; p++) begin
      if (xs[p]) v[p] = 1'b0;
      if (!v[p] && q[p].size() > 0) begin
        o = q[p].pop_front();
        v[p] = 1'b1;
        we_[p] = o.we;
        ad[p] = AW'(o.addr);
        wd[p] = DW'(o.data);
      end
    end
  endtask

  task automatic push(input int p, input bit w, input int a, input int d);
    op_t o;
    o.we = w;
    o.addr = a;
    o.data = d;
    q[p].push_back(o);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((v != 0 || q[0].size() > 0 || q[1].size() > 0 || m_busy > 0 ||
            m_rv != 0) && n < 2000) begin
      step();
      n++;
    end
    check({tag, "_idle_timeout"}, n < 2000, 1);
    step();
    step();
  endtask

  task automatic clear_logs();
    glog.delete();
    gcyc.delete();
    rlog[0].delete();
    rlog[1].delete();
    busy_cycles = 0;
  endtask

  function automatic int at(input int qq[$], input int i);
    return (qq.size() > i) ? qq[i] : -1;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int pool [8];
    int d;
    ad[0] = '0; ad[1] = '0; wd[0] = '0; wd[1] = '0;
    pool = '{11'h7FF, 11'h010, 11'h020, 11'h100, 11'h101, 11'h000, 11'h300, 11'h3FF};
    #1 rst = 1'b1;
    chk_on = 1;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    #1;
    check("rst_ready", r, 0);
    check("rst_rvalid", rv, 0);
    check("rst_rdata0", rd[0], 0);
    check("rst_rdata1", rd[1], 0);
    check("rst_busy", busy, 0);
    check("rst_last_grant", last_grant, 1);

    // Single-port write/read through the host port
    clear_logs();
    push(1, 1, 'h7FF, 'hA5);
    push(1, 0, 'h7FF, 0);
    wait_idle("single");
    check("single_p1_rdata", at(rlog[1], 0), 'hA5);
    check("single_p1_count", rlog[1].size(), 1);
    check("single_p0_count", rlog[0].size(), 0);

    // Contention: both ports hold reads, grants must alternate
    push(1, 1, 'h010, 'h11);
    push(1, 1, 'h020, 'h22);
    wait_idle("preload");
    clear_logs();
    push(0, 0, 'h010, 0);
    push(0, 0, 'h010, 0);
    push(1, 0, 'h020, 0);
    push(1, 0, 'h020, 0);
    wait_idle("contend");
    for (int i = 0; i < 4; i++) check($sformatf("contend_gnt%0d", i), at(glog, i), i % 2);
    check("contend_p0_rd0", at(rlog[0], 0), 'h11);
    check("contend_p0_rd1", at(rlog[0], 1), 'h11);
    check("contend_p1_rd0", at(rlog[1], 0), 'h22);
    check("contend_p1_rd1", at(rlog[1], 1), 'h22);

    // Cross-port read-after-write
    clear_logs();
    push(0, 1, 'h100, 'h3C);
    step();
    push(1, 0, 'h100, 0);
    wait_idle("raw1");
    check("raw1_p1_rdata", at(rlog[1], 0), 'h3C);
    clear_logs();
    push(0, 1, 'h101, 'h5A);
    push(1, 0, 'h101, 0);
    wait_idle("raw2");
    check("raw2_order0", at(glog, 0), 0);
    check("raw2_order1", at(glog, 1), 1);
    check("raw2_p1_rdata", at(rlog[1], 0), 'h5A);

    // Write-cycle stall timing
    clear_logs();
    push(0, 1, 'h200, 'h66);
    push(1, 0, 'h200, 0);
    wait_idle("twr");
    check("twr_gap", at(gcyc, 1) - at(gcyc, 0), (BUSY_ON != 0) ? TWR + 1 : 1);
    check("twr_busy_cycles", busy_cycles, (BUSY_ON != 0) ? TWR : 0);
    check("twr_p1_rdata", at(rlog[1], 0), 'h66);

    // Reset right after a read transfer drops the rvalid pulse
    clear_logs();
    push(1, 0, 'h7FF, 0);
    step();
    @(negedge clk);
    #1;
    check("midrst_xfer", xs[1], 1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    v = 2'b00;
    @(posedge clk);
    #1;
    // A write presented only while reset is held must not land
    v[0] = 1'b1; we_[0] = 1'b1; ad[0] = 11'h7FF; wd[0] = 8'h00;
    @(posedge clk);
    #1;
    v[0] = 1'b0;
    rst = 1'b0;
    step();
    check("midrst_no_rvalid", rlog[1].size(), 0);
    push(1, 0, 'h7FF, 0);
    wait_idle("midrst");
    check("midrst_keep_data", at(rlog[1], 0), 'hA5);

    // Reset during a write cycle clears busy at once
    clear_logs();
    push(0, 1, 'h300, 'h77);
    step();
    step();
    step();
    #1 rst = 1'b1;
    #1;
    check("busyrst_busy", busy, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    push(1, 0, 'h300, 0);
    step();
    @(negedge clk);
    #1;
    check("busyrst_grant_now", xs[1], 1);
    wait_idle("busyrst");
    check("busyrst_rdata", at(rlog[1], 0), 'h77);

    // Randomised traffic on a small address pool
    for (int i = 0; i < 400; i++) begin
      for (int p = 0; p < 2; p++) begin
        if (q[p].size() < 2 && $urandom_range(0, 2) == 0) begin
          d = int'($urandom_range(0, 255));
          push(p, 1'($urandom_range(0, 1)), pool[$urandom_range(0, 7)], d);
        end
      end
      step();
    end
    wait_idle("random");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
